friscv_rv32i_prefetch: RTL and testbench

- Instruction prefetch buffer between friscv_rv32i_control's instruction port (inst_en/inst_addr/inst_rdata/inst_ready) and the instruction memory.
- Speculatively fetches sequential words ahead of the control unit, so a sequential request is served the same cycle it is made.
- A non-sequential request (branch or jump) flushes the buffer and restarts fetching at the requested address.

---
 rtl/friscv_rv32i_prefetch_pkg.sv | 17 +
 rtl/friscv_pf_buffer.sv | 55 +++++
 rtl/friscv_rv32i_prefetch.sv | 98 +++++++++
 tb/tb_friscv_rv32i_prefetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/friscv_rv32i_prefetch_pkg.sv
`default_nettype none
//==============================================================================
// Module : friscv_rv32i_prefetch_pkg
// Brief  : Shared constants for the instruction prefetch buffer.
// Rev    : 1.0
//==============================================================================
package friscv_rv32i_prefetch_pkg;

  localparam int PF_DEPTH    = 4;
  localparam int PF_WORD_INC = 4;

  function automatic int pf_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/friscv_pf_buffer.sv
`default_nettype none
//==============================================================================
// Module : friscv_pf_buffer
// Brief  : DEPTH x XLEN synchronous FIFO with flush-to-empty, count and head.
// Rev    : 1.0
//==============================================================================
module friscv_pf_buffer
  import friscv_rv32i_prefetch_pkg::*;
#(
  parameter int DEPTH = PF_DEPTH,
  parameter int XLEN  = 32
)(
  input  logic                             aclk,
  input  logic                             srst,
  input  logic                             flush_i,
  input  logic                             push_i,
  input  logic [XLEN-1:0]                  wdata_i,
  input  logic                             pop_i,
  output logic [pf_cnt_width(DEPTH)-1:0]   count_o,
  output logic [XLEN-1:0]                  head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = pf_cnt_width(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;

  always_ff @(posedge aclk) begin
    if (srst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/friscv_rv32i_prefetch.sv
`default_nettype none
//==============================================================================
// Module : friscv_rv32i_prefetch
// Brief  : Sequential instruction prefetcher with zero-cycle hits and flush.
// Rev    : 1.0
//==============================================================================
module friscv_rv32i_prefetch
  import friscv_rv32i_prefetch_pkg::*;
#(
  parameter int               ADDRW     = 16,
  parameter int               XLEN      = 32,
  parameter logic [ADDRW-1:0] BOOT_ADDR = '0,
  parameter int               DEPTH     = PF_DEPTH
)(
  input  logic             aclk,
  input  logic             srst,
  input  logic             inst_en,
  input  logic [ADDRW-1:0] inst_addr,
  output logic [XLEN-1:0]  inst_rdata,
  output logic             inst_ready,
  output logic             mem_req,
  output logic [ADDRW-1:0] mem_addr,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata
);

  localparam int               CW       = pf_cnt_width(DEPTH);
  localparam logic [ADDRW-1:0] WORD_INC = ADDRW'(PF_WORD_INC);

  logic [ADDRW-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDRW-1:0] exp_addr_q, exp_addr_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    discard_q, discard_d;
  logic [CW-1:0]    inflight_next, discard_next;
  logic [CW-1:0]    count;
  logic [CW:0]      occupancy;
  logic [XLEN-1:0]  head;
  logic [ADDRW-1:0] target;
  logic             flush, hit, ret_live, push;

  assign target    = inst_addr & ~ADDRW'(3);
  assign flush     = inst_en && (target != exp_addr_q);
  assign occupancy = {1'b0, count} + {1'b0, inflight_q};
  // One slot per outstanding live read is reserved, so a return never finds the FIFO full.
  assign mem_req   = !srst && !flush && (occupancy < (CW+1)'(DEPTH));
  assign hit       = !srst && inst_en && !flush && (count != '0);
  assign ret_live  = mem_rvalid && (discard_q == '0);
  assign push      = ret_live && !flush;

  assign inst_ready = hit;
  assign inst_rdata = (count != '0) ? head : '0;
  assign mem_addr   = fetch_addr_q;

  always_comb begin
    inflight_next = inflight_q - CW'(ret_live) + CW'(mem_req);
    discard_next  = discard_q - CW'(mem_rvalid && (discard_q != '0));
    fetch_addr_d  = mem_req ? fetch_addr_q + WORD_INC : fetch_addr_q;
    exp_addr_d    = hit ? exp_addr_q + WORD_INC : exp_addr_q;
    inflight_d    = inflight_next;
    discard_d     = discard_next;
    if (flush) begin
      fetch_addr_d = target;
      exp_addr_d   = target;
      inflight_d   = '0;
      discard_d    = discard_next + inflight_next;
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      fetch_addr_q <= BOOT_ADDR;
      exp_addr_q   <= BOOT_ADDR;
      inflight_q   <= '0;
      discard_q    <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      exp_addr_q   <= exp_addr_d;
      inflight_q   <= inflight_d;
      discard_q    <= discard_d;
    end
  end

  friscv_pf_buffer #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_buffer (
    .aclk    (aclk),
    .srst    (srst),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (mem_rdata),
    .pop_i   (hit),
    .count_o (count),
    .head_o  (head)
  );

endmodule
`default_nettype wire

// File: tb/tb_friscv_rv32i_prefetch.sv
`default_nettype none
//==============================================================================
// Module : tb_friscv_rv32i_prefetch
// Brief  : Randomized self-checking bench with a queue-level reference model.
// Rev    : 1.0
//==============================================================================
module tb_friscv_rv32i_prefetch;

  localparam int DEPTH = 4;

  logic        aclk = 1'b0;
  logic        srst = 1'b1;
  logic        inst_en = 1'b0;
  logic [15:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 aclk = ~aclk;

  friscv_rv32i_prefetch #(
    .ADDRW     (16),
    .XLEN      (32),
    .BOOT_ADDR (16'h0000),
    .DEPTH     (DEPTH)
  ) dut (
    .aclk       (aclk),
    .srst       (srst),
    .inst_en    (inst_en),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_ready (inst_ready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } mret_t;

  mret_t       mq[$];
  logic [31:0] m_buf[$];
  bit          m_pend[$];
  logic [15:0] m_fetch, m_exp;
  int          cyc, last_due, lat, n_checks, n_fail, req_seen;
  bit          last_ready;

  function automatic logic [31:0] mem_data(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic en, input logic [15:0] a, input logic rst);
    bit          flush, e_ready, e_req, stale;
    int          n_live;
    logic [15:0] aa;
    @(posedge aclk);
    #1;
    srst      = rst;
    inst_en   = en;
    inst_addr = a;
    if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mq[0].data;
      void'(mq.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    @(negedge aclk);
    last_ready = inst_ready;
    if (mem_req) req_seen++;
    if (rst) begin
      check("rst_ready", 32'(inst_ready), 32'd0);
      check("rst_req", 32'(mem_req), 32'd0);
      m_buf.delete();
      m_pend.delete();
      mq.delete();
      m_fetch  = 16'h0000;
      m_exp    = 16'h0000;
      last_due = cyc;
    end else begin
      aa     = {a[15:2], 2'b00};
      flush  = en && (aa != m_exp);
      n_live = 0;
      foreach (m_pend[i]) if (!m_pend[i]) n_live++;
      e_ready = en && !flush && (m_buf.size() > 0);
      e_req   = !flush && ((m_buf.size() + n_live) < DEPTH);
      check("ready", 32'(inst_ready), 32'(e_ready));
      check("req", 32'(mem_req), 32'(e_req));
      if (e_req) check("addr", 32'(mem_addr), 32'(m_fetch));
      if (e_ready && inst_ready) check("rdata", inst_rdata, mem_data(aa));
      if (m_buf.size() == 0) check("rdata_empty", inst_rdata, 32'd0);
      if (mem_rvalid) begin
        if (m_pend.size() == 0) begin
          check("spurious_return", 32'd1, 32'd0);
        end else begin
          stale = m_pend.pop_front();
          if (!stale && !flush) m_buf.push_back(mem_rdata);
        end
      end
      if (e_ready) begin
        void'(m_buf.pop_front());
        m_exp = m_exp + 16'd4;
      end
      if (flush) begin
        m_buf.delete();
        foreach (m_pend[i]) m_pend[i] = 1'b1;
        m_exp   = aa;
        m_fetch = aa;
      end else if (e_req) begin
        m_pend.push_back(1'b0);
        last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        mq.push_back('{due: last_due, data: mem_data(m_fetch)});
        m_fetch = m_fetch + 16'd4;
      end
    end
    cyc++;
  endtask

  task automatic fetch_word(input logic [15:0] a, input int budget, output int waited);
    waited     = 0;
    last_ready = 1'b0;
    while (!last_ready && waited < budget) begin
      step(1'b1, a, 1'b0);
      waited++;
    end
    if (!last_ready) check("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int          w, r;
    logic [15:0] cur;
    n_checks = 0; n_fail = 0; cyc = 0; last_due = 0; lat = 1; req_seen = 0;
    m_fetch = '0; m_exp = '0;

    // Boot stream, latency 1.
    step(1'b0, 16'h0, 1'b1);
    fetch_word(16'h0000, 20, w);
    check("boot_latency", 32'(w), 32'd3);
    for (int i = 1; i < 16; i++) begin
      fetch_word(16'(i * 4), 20, w);
      check("stream_rate", 32'(w), 32'd1);
    end

    // Full hold, latency 3.
    step(1'b0, 16'h0, 1'b1);
    lat = 3;
    req_seen = 0;
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b0);
    check("hold_reqs", 32'(req_seen), 32'(DEPTH));
    for (int i = 0; i < 4; i++) fetch_word(16'(i * 4), 1, w);

    // Branch flush to 0x40.
    step(1'b1, 16'h0040, 1'b0);
    check("flush_noready", 32'(inst_ready), 32'd0);
    fetch_word(16'h0040, 20, w);
    fetch_word(16'h0044, 20, w);

    // Flush with three reads in flight, latency 5.
    step(1'b0, 16'h0, 1'b1);
    lat = 5;
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0);
    fetch_word(16'h0100, 30, w);
    fetch_word(16'h0104, 30, w);

    // Flush coinciding with a return, one more outstanding.
    step(1'b0, 16'h0, 1'b1);
    lat = 2;
    for (int i = 0; i < 2; i++) step(1'b0, 16'h0, 1'b0);
    fetch_word(16'h0200, 30, w);
    fetch_word(16'h0204, 30, w);

    // Address wrap and mid-stream reset.
    step(1'b0, 16'h0, 1'b1);
    lat = 1;
    fetch_word(16'hFFF8, 20, w);
    fetch_word(16'hFFFC, 5, w);
    fetch_word(16'h0000, 5, w);
    step(1'b1, 16'h0004, 1'b1);
    step(1'b0, 16'h0, 1'b0);
    check("boot_restart", 32'(mem_addr), 32'h0);
    fetch_word(16'h0000, 20, w);

    // Randomized control traffic.
    step(1'b0, 16'h0, 1'b1);
    cur = 16'h0000;
    for (int n = 0; n < 3000; n++) begin
      r   = $urandom_range(0, 199);
      lat = $urandom_range(1, 5);
      if (r == 0) begin
        step(1'b0, 16'h0, 1'b1);
        cur = 16'h0000;
      end else if (r < 12) begin
        cur = 16'($urandom) & 16'hFFFC;
        step(1'b1, cur, 1'b0);
      end else if (r < 40) begin
        step(1'b0, cur, 1'b0);
      end else if (r < 48) begin
        step(1'b1, cur | 16'($urandom_range(1, 3)), 1'b0);
      end else begin
        step(1'b1, cur, 1'b0);
      end
      if (last_ready) cur = cur + 16'd4;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
